// File: rtl/gray_pkg.sv
// Shared constants for the Gray-count monitor: sample width and FSM encoding.
// No logic; pure declarations.
// Imported by gray2bin and gray_monitor.
package gray_pkg;

  localparam int GRAY_W = 3;

  // 2-bit FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;  // no baseline captured yet
  localparam logic [1:0] ST_TRACK  = 2'd1;  // checking every sample against prev+1
  localparam logic [1:0] ST_RESYNC = 2'd2;  // after a violation, waiting for a new baseline

endpackage

// File: rtl/gray2bin.sv
// Combinational 3-bit Gray-to-binary converter.
// Zero latency (pure logic).
// No handshake; output follows input.
module gray2bin
  import gray_pkg::*;
(
  input  logic [GRAY_W-1:0] i_gray,
  output logic [GRAY_W-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at or above it
  assign o_bin = {i_gray[2], i_gray[2] ^ i_gray[1], i_gray[2] ^ i_gray[1] ^ i_gray[0]};

endmodule

// File: rtl/gray_monitor.sv
// Converts an upstream 3-bit Gray count to binary and checks its step sequence.
// One cycle from a Valid sample to Bin/Bin_valid and any Wrap/Step_err pulse.
// No backpressure; every Valid sample is accepted unless Clear is high.
module gray_monitor
  import gray_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [GRAY_W-1:0] i_gray,
  input  logic              i_overflow,
  input  logic              i_clear,
  output logic [GRAY_W-1:0] o_bin,
  output logic              o_bin_valid,
  output logic              o_wrap,
  output logic              o_step_err,
  output logic              o_err_flag,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic [CNT_W-1:0]  o_wrap_cnt,
  output logic              o_locked
);

  logic [1:0]        r_state;
  logic [GRAY_W-1:0] r_bin;      // doubles as the "prev" value for step checking
  logic              r_bin_valid;
  logic              r_wrap;
  logic              r_step_err;
  logic              r_err_flag;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [CNT_W-1:0]  r_wrap_cnt;

  logic [GRAY_W-1:0] w_bin;
  logic [GRAY_W-1:0] w_expect;
  logic              w_prev_max;
  logic              w_legal;

  gray2bin u_gray2bin (
    .i_gray (i_gray),
    .o_bin  (w_bin)
  );

  assign w_expect   = r_bin + GRAY_W'(1);
  assign w_prev_max = (r_bin == '1);
  // A step is legal only if it advances by one and the overflow flag marks exactly the 7->0 step
  assign w_legal    = (w_bin == w_expect) && (i_overflow == w_prev_max);

  // FSM, sample capture, one-cycle pulses and counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_bin       <= '0;
      r_bin_valid <= 1'b0;
      r_wrap      <= 1'b0;
      r_step_err  <= 1'b0;
      r_err_flag  <= 1'b0;
      r_err_cnt   <= '0;
      r_wrap_cnt  <= '0;
    end else begin
      r_bin_valid <= 1'b0;
      r_wrap      <= 1'b0;
      r_step_err  <= 1'b0;
      if (i_clear) begin
        // Clear wins over a coincident sample; Bin keeps its last value
        r_state    <= ST_IDLE;
        r_err_flag <= 1'b0;
        r_err_cnt  <= '0;
        r_wrap_cnt <= '0;
      end else if (i_valid) begin
        r_bin       <= w_bin;
        r_bin_valid <= 1'b1;
        case (r_state)
          ST_TRACK: begin
            if (w_legal) begin
              if (w_prev_max) begin
                r_wrap     <= 1'b1;
                r_wrap_cnt <= r_wrap_cnt + CNT_W'(1);
              end
            end else begin
              r_step_err <= 1'b1;
              r_err_flag <= 1'b1;
              if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
              end
              r_state <= ST_RESYNC;
            end
          end
          // IDLE and RESYNC both take the sample as an unchecked baseline
          default: r_state <= ST_TRACK;
        endcase
      end
    end
  end

  assign o_bin       = r_bin;
  assign o_bin_valid = r_bin_valid;
  assign o_wrap      = r_wrap;
  assign o_step_err  = r_step_err;
  assign o_err_flag  = r_err_flag;
  assign o_err_cnt   = r_err_cnt;
  assign o_wrap_cnt  = r_wrap_cnt;
  assign o_locked    = (r_state == ST_TRACK);

endmodule

// File: doc/gray_monitor.md
GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 Parameter CNT_W, default 8, sets the width of the error and wrap counters; legal range 2..16.
REQ-002 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; asserting low immediately forces the reset state, deassertion is released on Clk.
REQ-004 Valid  input  1  high for one cycle per new upstream count sample (driven from the counter's En).
REQ-005 Gray  input  3  Gray-coded count from the upstream 3-bit Gray counter.
REQ-006 Overflow_in  input  1  upstream overflow flag sampled together with Gray.
REQ-007 Clear  input  1  synchronous clear of counters, sticky flag and lock.
REQ-008 Bin  output  3  registered binary equivalent of the last accepted Gray sample.
REQ-009 Bin_valid  output  1  one-cycle pulse marking a fresh Bin.
REQ-010 Wrap  output  1  one-cycle pulse on a legal 7->0 transition.
REQ-011 Step_err  output  1  one-cycle pulse on any sequence or overflow violation.
REQ-012 Err_flag  output  1  sticky error indicator.
REQ-013 Err_cnt  output  CNT_W  saturating count of violations.
REQ-014 Wrap_cnt  output  CNT_W  wrapping count of legal wraps.
REQ-015 Locked  output  1  high while state is TRACK.

Function
REQ-016 Conversion SHALL be Gray to binary: b2=g2, b1=g2^g1, b0=g2^g1^g0.
REQ-017 Latency SHALL be one cycle: a sample with Valid at edge N appears on Bin with Bin_valid=1, and with any Wrap/Step_err pulse, after edge N; Bin holds between samples.
REQ-018 FSM states: IDLE (no baseline), TRACK (checking), RESYNC (after violation).
REQ-019 IDLE: a Valid sample is converted and stored as the baseline without checking; next state TRACK.
REQ-020 TRACK: a Valid sample is legal iff new == (prev+1) mod 8 and Overflow_in == (prev==7); otherwise it is a violation.
REQ-021 TRACK: a legal sample with prev=7 and new=0 SHALL pulse Wrap and increment Wrap_cnt, rolling over from all-ones to 0.
REQ-022 TRACK: a violation SHALL pulse Step_err, set Err_flag, increment Err_cnt (saturating at all-ones), store the sample as prev, and transition to RESYNC.
REQ-023 RESYNC: the next Valid sample SHALL be accepted as a new baseline without checking and SHALL return the FSM to TRACK.
REQ-024 Cycles without Valid SHALL change no state, counter or prev value.
REQ-025 Clear SHALL return the FSM to IDLE, zero Err_cnt, Wrap_cnt and Err_flag, and suppress pulses; Clear with Valid in the same cycle SHALL discard the sample.
REQ-026 Locked SHALL equal 1 only in TRACK.

Reset
REQ-027 While Reset is low: FSM=IDLE, prev=0, Bin=0, Bin_valid=0, Wrap=0, Step_err=0, Err_flag=0, Err_cnt=0, Wrap_cnt=0, Locked=0.
REQ-028 Reset asserted mid-sequence SHALL abort tracking; the first Valid after release SHALL be treated as an IDLE baseline.

Structure
REQ-029 Shared package gray_pkg SHALL hold the FSM state encoding (2-bit) and the GRAY_W=3 constant.
REQ-030 The conversion SHALL be a combinational sub-module gray2bin (3-bit in, 3-bit out), instantiated once.

Verification
REQ-031 Reset release, Valid every cycle with Gray 000,001,011,010 and Overflow_in=0 -> Bin 0,1,2,3; Locked=1 from the second Bin_valid; Step_err never asserted.
REQ-032 Full sequence through 100 (bin 7) then 000 with Overflow_in=1 -> Wrap pulse, Wrap_cnt=1, Err_cnt=0.
REQ-033 Prev bin 2, then Gray 110 (bin 4) -> Step_err pulse, Err_flag=1, Err_cnt=1, Locked=0; next sample 111 (bin 5) -> Locked=1, no error; following sample 101 (bin 6) -> no error.
REQ-034 Legal step 3->4 arriving with Overflow_in=1 -> Step_err pulse, Err_cnt increments.
REQ-035 With CNT_W=2, four violations -> Err_cnt stays at 3.
REQ-036 Clear and Valid asserted together while Err_cnt=2 -> Err_cnt=0, Err_flag=0, FSM in IDLE, no Bin_valid; Reset pulsed low mid-sequence -> all outputs 0 asynchronously.
